// File: rtl/retire_trace_if.sv
// Retire-side and read-side bus for retire_trace_buffer.
// The master modport is the core/consumer side. The slave modport is the trace buffer.
// Defining TRACE_REGWRITE_EN adds the register-writeback fields to both sides.
interface retire_trace_if #(
    parameter int XLEN = 32
);
    // Retire side. One entry is offered on each cycle that retire_valid is high.
    // There is no ready signal on this side, because the buffer never stalls the core.
    logic            retire_valid;
    logic [XLEN-1:0] retire_pc;
    logic [31:0]     retire_inst;
    logic [XLEN-1:0] retire_alu;

    // Read side handshake:
    // - An entry transfers on every rising edge where rd_valid and rd_ready are both high.
    // - Once rd_valid is high, rd_pc, rd_inst and rd_alu stay stable until that transfer.
    // - rd_valid does not depend on rd_ready.
    logic            rd_valid;
    logic            rd_ready;
    logic [XLEN-1:0] rd_pc;
    logic [31:0]     rd_inst;
    logic [XLEN-1:0] rd_alu;

`ifdef TRACE_REGWRITE_EN
    logic            retire_rd_we;
    logic [4:0]      retire_rd;
    logic [XLEN-1:0] retire_rd_data;
    logic            rd_rd_we;
    logic [4:0]      rd_rd;
    logic [XLEN-1:0] rd_rd_data;
`endif

    modport master (
        output retire_valid, retire_pc, retire_inst, retire_alu,
`ifdef TRACE_REGWRITE_EN
        output retire_rd_we, retire_rd, retire_rd_data,
        input  rd_rd_we, rd_rd, rd_rd_data,
`endif
        output rd_ready,
        input  rd_valid, rd_pc, rd_inst, rd_alu
    );

    modport slave (
        input  retire_valid, retire_pc, retire_inst, retire_alu,
`ifdef TRACE_REGWRITE_EN
        input  retire_rd_we, retire_rd, retire_rd_data,
        output rd_rd_we, rd_rd, rd_rd_data,
`endif
        input  rd_ready,
        output rd_valid, rd_pc, rd_inst, rd_alu
    );
endinterface

// File: rtl/retire_trace_buffer.sv
// Retirement trace capture buffer for the single-cycle RV32 core.
// - An arm pulse starts a capture.
// - Retired {pc, inst, alu_out} tuples are stored in stop-when-full or wrap mode.
// - Entries are replayed oldest first over a first-word-fall-through valid/ready port.
// Defining TRACE_REGWRITE_EN also stores and replays the register-writeback fields.
module retire_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           arm,
    input  logic           stop,
    input  logic           mode,
    input  logic [CW-1:0]  cap_len,
    retire_trace_if.slave  bus,
    output logic           busy,
    output logic           done,
    output logic [CW-1:0]  count,
    output logic           overflow,
    output logic [1:0]     state_dbg
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t          state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   captured;
    logic [CW-1:0]   len_q;
    logic            mode_q;
    logic [CW-1:0]   eff_len;
    logic            full;
    logic            wr_en;
    logic            pop;

    logic [XLEN-1:0] mem_pc   [DEPTH];
    logic [31:0]     mem_inst [DEPTH];
    logic [XLEN-1:0] mem_alu  [DEPTH];
`ifdef TRACE_REGWRITE_EN
    logic            mem_we   [DEPTH];
    logic [4:0]      mem_rd   [DEPTH];
    logic [XLEN-1:0] mem_rdd  [DEPTH];
`endif

    // A cap_len of 0, or one larger than the buffer, means "fill the whole buffer".
    always_comb begin
        eff_len = cap_len;
        if (cap_len == '0 || cap_len > DEPTH_C) begin
            eff_len = DEPTH_C;
        end
    end

    assign full      = (count == DEPTH_C);
    assign wr_en     = (state == S_CAPTURE) && bus.retire_valid;
    assign bus.rd_valid = (state == S_DRAIN) && (count != '0);
    assign pop       = bus.rd_valid && bus.rd_ready;
    assign state_dbg = state;

    // Read data falls through from the oldest slot, so it is stable until that slot is popped.
    assign bus.rd_pc   = mem_pc[rd_ptr];
    assign bus.rd_inst = mem_inst[rd_ptr];
    assign bus.rd_alu  = mem_alu[rd_ptr];
`ifdef TRACE_REGWRITE_EN
    assign bus.rd_rd_we   = mem_we[rd_ptr];
    assign bus.rd_rd      = mem_rd[rd_ptr];
    assign bus.rd_rd_data = mem_rdd[rd_ptr];
`endif

    // Entry storage, written at wr_ptr on each captured retire. It has no reset because contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_pc[wr_ptr]   <= bus.retire_pc;
            mem_inst[wr_ptr] <= bus.retire_inst;
            mem_alu[wr_ptr]  <= bus.retire_alu;
`ifdef TRACE_REGWRITE_EN
            mem_we[wr_ptr]   <= bus.retire_rd_we;
            mem_rd[wr_ptr]   <= bus.retire_rd;
            mem_rdd[wr_ptr]  <= bus.retire_rd_data;
`endif
        end
    end

    // Capture/drain controller: owns the pointers, occupancy and sticky overflow, and registers busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            captured <= '0;
            len_q    <= '0;
            mode_q   <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arm) begin
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        count    <= '0;
                        captured <= '0;
                        overflow <= 1'b0;
                        mode_q   <= mode;
                        len_q    <= eff_len;
                        state    <= S_CAPTURE;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end

                S_CAPTURE: begin
                    if (wr_en) begin
                        wr_ptr <= wr_ptr + AW'(1);
                        if (mode_q && full) begin
                            // In wrap mode a full buffer drops its oldest entry to make room.
                            rd_ptr   <= rd_ptr + AW'(1);
                            overflow <= 1'b1;
                        end else begin
                            count <= count + CW'(1);
                        end
                        if (!mode_q) begin
                            captured <= captured + CW'(1);
                        end
                    end
                    // A retire in the same cycle as stop is kept, because the write above still happens.
                    if (stop || (!mode_q && wr_en && (captured + CW'(1)) == len_q)) begin
                        state <= S_DRAIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                S_DRAIN: begin
                    if (pop) begin
                        rd_ptr <= rd_ptr + AW'(1);
                        count  <= count - CW'(1);
                    end
                    if (count == '0 || (pop && count == CW'(1))) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_retire_trace_buffer.sv
// Self-checking bench for retire_trace_buffer.
// The reference model is an entry queue that follows the capture rules:
// - stop mode stops at the effective length;
// - wrap mode keeps the newest DEPTH entries;
// - drain pops the queue oldest first.
module tb_retire_trace_buffer;
    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int EW    = 2 * XLEN + 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm;
    logic          stop;
    logic          mode;
    logic [CW-1:0] cap_len;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;
    logic          overflow;
    logic [1:0]    state_dbg;

    retire_trace_if #(.XLEN(XLEN)) bus ();

    retire_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .stop      (stop),
        .mode      (mode),
        .cap_len   (cap_len),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .overflow  (overflow),
        .state_dbg (state_dbg)
    );

    // Clock and reset
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model state
    logic [EW-1:0] exp_q[$];
    bit            m_cap;
    bit            m_mode;
    int            m_len;
    bit            m_ovf;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input bit md, input int len);
        arm = 1'b1;
        mode = md;
        cap_len = CW'(len);
        tick();
        arm = 1'b0;
        exp_q.delete();
        m_cap  = 1'b1;
        m_mode = md;
        m_len  = (len == 0 || len > DEPTH) ? DEPTH : len;
        m_ovf  = 1'b0;
    endtask

    task automatic drive(input bit rv, input logic [XLEN-1:0] pc, input bit st);
        logic [31:0]     inst;
        logic [XLEN-1:0] alu;
        inst = $urandom;
        alu  = $urandom;
        bus.retire_valid = rv;
        bus.retire_pc    = pc;
        bus.retire_inst  = inst;
        bus.retire_alu   = alu;
        stop = st;
        tick();
        bus.retire_valid = 1'b0;
        stop = 1'b0;
        if (m_cap) begin
            if (rv) begin
                exp_q.push_back({pc, inst, alu});
                if (exp_q.size() > DEPTH) begin
                    void'(exp_q.pop_front());
                    m_ovf = 1'b1;
                end
            end
            if (st || (!m_mode && rv && exp_q.size() == m_len)) m_cap = 1'b0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cap = 1'b0;
        m_ovf = 1'b0;
    endtask

    // Drain until the model is empty. ready_mode: 0 = always ready, 1 = random, 2 = toggle.
    task automatic drain_all(input string name, input int ready_mode);
        int budget;
        bit rdy;
        bit tog;
        budget = 400;
        tog = 1'b1;
        total_cnt++;
        if (overflow !== m_ovf) $display("FAIL %s overflow: got %b want %b", name, overflow, m_ovf);
        else pass_cnt++;
        while (exp_q.size() > 0 && budget > 0) begin
            total_cnt++;
            if (bus.rd_valid !== 1'b1 || count !== CW'(exp_q.size()))
                $display("FAIL %s valid/count: got valid=%b count=%0d want valid=1 count=%0d",
                         name, bus.rd_valid, count, exp_q.size());
            else pass_cnt++;
            total_cnt++;
            if ({bus.rd_pc, bus.rd_inst, bus.rd_alu} !== exp_q[0])
                $display("FAIL %s data: got %h want %h", name, {bus.rd_pc, bus.rd_inst, bus.rd_alu}, exp_q[0]);
            else pass_cnt++;
            case (ready_mode)
                0: rdy = 1'b1;
                1: rdy = 1'($urandom_range(0, 1));
                default: begin rdy = tog; tog = ~tog; end
            endcase
            bus.rd_ready = rdy;
            tick();
            bus.rd_ready = 1'b0;
            if (rdy) void'(exp_q.pop_front());
            budget--;
        end
        total_cnt++;
        if (budget == 0) $display("FAIL %s drain timeout: got %0d entries left want 0", name, exp_q.size());
        else pass_cnt++;
        total_cnt++;
        if (bus.rd_valid !== 1'b0 || count !== '0)
            $display("FAIL %s empty: got valid=%b count=%0d want valid=0 count=0", name, bus.rd_valid, count);
        else pass_cnt++;
        budget = 3;
        while (done === 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s idle: got busy=%b done=%b want 0/0", name, busy, done);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset busy/done: got %b/%b want 0/0", busy, done);
        else pass_cnt++;
        total_cnt++;
        if (count !== '0 || overflow !== 1'b0) $display("FAIL reset count/ovf: got %0d/%b want 0/0", count, overflow);
        else pass_cnt++;
        total_cnt++;
        if (bus.rd_valid !== 1'b0) $display("FAIL reset rd_valid: got %b want 0", bus.rd_valid);
        else pass_cnt++;
    endtask

    task automatic test_stop_mode();
        do_arm(1'b0, 4);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL stop arm_busy: got %b want 1", busy);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, XLEN'(i * 4), 1'b0);
            if (i == 3) begin
                total_cnt++;
                if (busy !== 1'b0 || done !== 1'b1) $display("FAIL stop busy_drop: got busy=%b done=%b want 0/1", busy, done);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (count !== CW'(4) || bus.rd_pc !== 32'd0) $display("FAIL stop held: got count=%0d pc=%0d want 4/0", count, bus.rd_pc);
        else pass_cnt++;
        drain_all("stop_drain", 0);
    endtask

    task automatic test_wrap_mode();
        do_arm(1'b1, 0);
        for (int i = 0; i < 20; i++) drive(1'b1, XLEN'(i * 4), 1'b0);
        drive(1'b0, '0, 1'b1);
        total_cnt++;
        if (count !== CW'(16) || overflow !== 1'b1 || done !== 1'b1)
            $display("FAIL wrap status: got count=%0d ovf=%b done=%b want 16/1/1", count, overflow, done);
        else pass_cnt++;
        total_cnt++;
        if (bus.rd_pc !== 32'd16) $display("FAIL wrap oldest: got pc=%0d want 16", bus.rd_pc);
        else pass_cnt++;
        drain_all("wrap_drain", 0);
    endtask

    task automatic test_stop_with_retire();
        do_arm(1'b0, 0);
        drive(1'b1, 32'h100, 1'b0);
        drive(1'b1, 32'h104, 1'b0);
        drive(1'b1, 32'h108, 1'b1);
        total_cnt++;
        if (count !== CW'(3) || done !== 1'b1) $display("FAIL stop_retire count: got %0d done=%b want 3/1", count, done);
        else pass_cnt++;
        drain_all("stop_retire_drain", 0);
    endtask

    task automatic test_empty_drain();
        do_arm(1'b0, 4);
        drive(1'b0, '0, 1'b1);
        total_cnt++;
        if (done !== 1'b1 || bus.rd_valid !== 1'b0 || count !== '0)
            $display("FAIL empty_drain enter: got done=%b valid=%b count=%0d want 1/0/0", done, bus.rd_valid, count);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL empty_drain exit: got done=%b busy=%b want 0/0", done, busy);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        do_arm(1'b0, 6);
        for (int i = 0; i < 6; i++) drive(1'b1, $urandom, 1'b0);
        for (int k = 0; k < 5; k++) begin
            bus.rd_ready = 1'b0;
            total_cnt++;
            if (bus.rd_pc !== exp_q[0][EW-1 -: XLEN] || count !== CW'(6))
                $display("FAIL bp hold: got pc=%h count=%0d want pc=%h count=6", bus.rd_pc, count, exp_q[0][EW-1 -: XLEN]);
            else pass_cnt++;
            tick();
        end
        drain_all("bp_toggle", 2);
    endtask

    task automatic test_reset_mid_capture();
        do_arm(1'b0, 10);
        for (int i = 0; i < 5; i++) drive(1'b1, $urandom, 1'b0);
        total_cnt++;
        if (count !== CW'(5) || busy !== 1'b1) $display("FAIL rst_mid pre: got count=%0d busy=%b want 5/1", count, busy);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0 || count !== '0 || overflow !== 1'b0)
            $display("FAIL rst_mid post: got busy=%b done=%b count=%0d ovf=%b want 0/0/0/0", busy, done, count, overflow);
        else pass_cnt++;
        do_arm(1'b1, 0);
        for (int i = 0; i < 18; i++) drive(1'b1, $urandom, 1'b0);
        total_cnt++;
        if (overflow !== 1'b1) $display("FAIL rst_mid wrap_ovf: got %b want 1", overflow);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        total_cnt++;
        if (overflow !== 1'b0 || count !== '0 || busy !== 1'b0)
            $display("FAIL rst_mid ovf_clear: got ovf=%b count=%0d busy=%b want 0/0/0", overflow, count, busy);
        else pass_cnt++;
        do_arm(1'b0, 3);
        for (int i = 0; i < 3; i++) drive(1'b1, $urandom, 1'b0);
        drain_all("rst_mid_rearm", 0);
    endtask

    task automatic test_arm_during_drain();
        do_arm(1'b0, 5);
        for (int i = 0; i < 5; i++) drive(1'b1, $urandom, 1'b0);
        for (int k = 0; k < 2; k++) begin
            total_cnt++;
            if ({bus.rd_pc, bus.rd_inst, bus.rd_alu} !== exp_q[0])
                $display("FAIL arm_drain pre_pop: got %h want %h", {bus.rd_pc, bus.rd_inst, bus.rd_alu}, exp_q[0]);
            else pass_cnt++;
            bus.rd_ready = 1'b1;
            tick();
            bus.rd_ready = 1'b0;
            void'(exp_q.pop_front());
        end
        arm = 1'b1;
        mode = 1'b1;
        cap_len = CW'(2);
        tick();
        arm = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b1 || count !== CW'(3))
            $display("FAIL arm_drain ignored: got busy=%b done=%b count=%0d want 0/1/3", busy, done, count);
        else pass_cnt++;
        drain_all("arm_drain_rest", 0);
    endtask

    task automatic test_cap_len_zero();
        do_arm(1'b0, 0);
        for (int i = 0; i < 18; i++) drive(1'b1, $urandom, 1'b0);
        total_cnt++;
        if (count !== CW'(16) || busy !== 1'b0 || overflow !== 1'b0)
            $display("FAIL caplen0: got count=%0d busy=%b ovf=%b want 16/0/0", count, busy, overflow);
        else pass_cnt++;
        drain_all("caplen0_drain", 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            bit md;
            int len;
            int n;
            md  = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 20);
            n   = $urandom_range(0, 40);
            do_arm(md, len);
            for (int i = 0; i < n; i++) drive($urandom_range(0, 3) != 0, $urandom, 1'b0);
            drive(1'b0, '0, 1'b1);
            drain_all("random", 1);
        end
    endtask

    // Scenario sequence and final report
    initial begin
        rst = 1'b1;
        arm = 1'b0;
        stop = 1'b0;
        mode = 1'b0;
        cap_len = '0;
        bus.retire_valid = 1'b0;
        bus.retire_pc = '0;
        bus.retire_inst = '0;
        bus.retire_alu = '0;
        bus.rd_ready = 1'b0;
`ifdef TRACE_REGWRITE_EN
        bus.retire_rd_we = 1'b0;
        bus.retire_rd = '0;
        bus.retire_rd_data = '0;
`endif
        test_reset();
        test_stop_mode();
        test_wrap_mode();
        test_stop_with_retire();
        test_empty_drain();
        test_backpressure();
        test_reset_mid_capture();
        test_arm_during_drain();
        test_cap_len_zero();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion want finish before timeout");
        $fatal(1, "watchdog expired");
    end
endmodule
